// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, fetch control and the
// decode-side valid/ready handshake.
interface instruction_fetch_unit_if;
  logic [63:0] Address;
  logic [31:0] Data;
  logic        FetchEnable;
  logic        Redirect;
  logic [63:0] RedirectPC;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] InstrOut;
  logic [63:0] PCOut;

  // Fetch unit side
  modport master (
    output Address, InstrValid, InstrOut, PCOut,
    input  Data, FetchEnable, Redirect, RedirectPC, InstrReady
  );

  // Memory / decode / control side
  modport slave (
    input  Address, InstrValid, InstrOut, PCOut,
    output Data, FetchEnable, Redirect, RedirectPC, InstrReady
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, waits out the memory read latency with
// a down-counter, buffers {pc, instr} pairs in a small FIFO for decode.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | counting down the read latency or capturing Data
// STALL | capture point reached with the FIFO full; Address held
// HALT  | FetchEnable low; pc and counter frozen, decode keeps draining
module instruction_fetch_unit #(
  parameter logic [63:0] PC_RESET   = 64'h0,
  parameter int          MEM_WAIT   = 1,
  parameter int          FIFO_DEPTH = 2
) (
  input logic                      CLK,
  input logic                      Reset,
  instruction_fetch_unit_if.master bus
);

  localparam int CW = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
  localparam int PW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] WAIT_RELOAD = CW'(MEM_WAIT);
  localparam logic [NW-1:0] DEPTH_N     = NW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR    = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

  state_t          state, state_nxt;
  logic [63:0]     pc, pc_nxt;
  logic [CW-1:0]   wait_cnt, wait_nxt;
  logic [63:0]     fifo_pc    [FIFO_DEPTH];
  logic [31:0]     fifo_instr [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [NW-1:0]   count;
  logic            head_valid, pop, push, flush, space;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign head_valid     = (count != '0);
  assign pop            = head_valid && bus.InstrReady;
  // A pop on the same edge frees a slot, so a full FIFO need not stall.
  assign space          = (count < DEPTH_N) || pop;
  assign bus.Address    = pc;
  assign bus.InstrValid = head_valid;
  assign bus.InstrOut   = head_valid ? fifo_instr[rd_ptr] : '0;
  assign bus.PCOut      = head_valid ? fifo_pc[rd_ptr]    : '0;

  // Next-state, next-pc and latency counter; redirect overrides everything.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    wait_nxt  = wait_cnt;
    push      = 1'b0;
    flush     = 1'b0;
    if (bus.Redirect) begin
      flush     = 1'b1;
      pc_nxt    = {bus.RedirectPC[63:2], 2'b00};
      wait_nxt  = WAIT_RELOAD;
      state_nxt = bus.FetchEnable ? RUN : HALT;
    end else if (!bus.FetchEnable) begin
      state_nxt = HALT;
    end else begin
      case (state)
        RUN: begin
          if (wait_cnt != '0) begin
            wait_nxt = wait_cnt - CW'(1);
          end else if (space) begin
            push     = 1'b1;
            pc_nxt   = pc + 64'd4;
            wait_nxt = WAIT_RELOAD;
          end else begin
            state_nxt = STALL;
          end
        end
        STALL: begin
          if (space) begin
            push      = 1'b1;
            pc_nxt    = pc + 64'd4;
            wait_nxt  = WAIT_RELOAD;
            state_nxt = RUN;
          end
        end
        HALT: begin
          // Address may have been idle long enough, but Data is re-waited anyway.
          wait_nxt  = WAIT_RELOAD;
          state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Control state, pc, counter and FIFO bookkeeping.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= RUN;
      pc       <= PC_RESET;
      wait_cnt <= WAIT_RELOAD;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      wait_cnt <= wait_nxt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
        if (push && !pop)      count <= count + NW'(1);
        else if (!push && pop) count <= count - NW'(1);
      end
    end
  end

  // FIFO storage; contents are qualified by count so they need no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= pc;
      fifo_instr[wr_ptr] <= bus.Data;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit (MEM_WAIT=1, FIFO_DEPTH=2).
module tb_instruction_fetch_unit;

  logic CLK;
  logic Reset;
  int   checks;
  int   errors;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .PC_RESET  (64'h0),
    .MEM_WAIT  (1),
    .FIFO_DEPTH(2)
  ) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  logic [31:0] exp_words [5] = '{32'hD2800140, 32'hD2800281, 32'hD28001E2,
                                 32'hD28000A3, 32'h0B010004};

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h000: return 32'hD2800140;
      64'h004: return 32'hD2800281;
      64'h008: return 32'hD28001E2;
      64'h00C: return 32'hD28000A3;
      64'h010: return 32'h0B010004;
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  assign bus.Data = mem_word(bus.Address);

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    Reset           = 1'b1;
    bus.FetchEnable = 1'b1;
    bus.Redirect    = 1'b0;
    bus.RedirectPC  = 64'h0;
    bus.InstrReady  = ready;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  // Expects reset just released with InstrReady=1; checks pushes at edges 2..10.
  task automatic check_stream(input string tag);
    logic        ev;
    logic [63:0] ea;
    checks++;
    if (bus.InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_c0 got %b exp 0", tag, bus.InstrValid);
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      ev = (k % 2 == 0);
      ea = 64'(4 * (k / 2));
      checks++;
      if (bus.InstrValid !== ev) begin
        errors++;
        $display("FAIL %s valid_e%0d got %b exp %b", tag, k, bus.InstrValid, ev);
      end
      checks++;
      if (bus.Address !== ea) begin
        errors++;
        $display("FAIL %s addr_e%0d got %h exp %h", tag, k, bus.Address, ea);
      end
      if (ev) begin
        checks++;
        if (bus.InstrOut !== exp_words[k/2-1]) begin
          errors++;
          $display("FAIL %s instr_e%0d got %h exp %h", tag, k, bus.InstrOut, exp_words[k/2-1]);
        end
        checks++;
        if (bus.PCOut !== 64'(4 * (k/2 - 1))) begin
          errors++;
          $display("FAIL %s pc_e%0d got %h exp %h", tag, k, bus.PCOut, 64'(4 * (k/2 - 1)));
        end
      end
    end
  endtask

  task automatic test_reset();
    Reset           = 1'b1;
    bus.FetchEnable = 1'b1;
    bus.Redirect    = 1'b0;
    bus.RedirectPC  = 64'h0;
    bus.InstrReady  = 1'b1;
    #2;
    checks++;
    if (bus.Address !== 64'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus.Address); end
    checks++;
    if (bus.InstrValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.InstrValid); end
    checks++;
    if (bus.InstrOut !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", bus.InstrOut); end
    checks++;
    if (bus.PCOut !== 64'h0) begin errors++; $display("FAIL reset_pcout got %h exp 0", bus.PCOut); end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    check_stream("stream");
  endtask

  task automatic test_stall();
    logic [63:0] ep [3] = '{64'h4, 64'h8, 64'hC};
    do_reset(1'b0);
    for (int k = 1; k <= 8; k++) tick();
    checks++;
    if (bus.Address !== 64'h8) begin errors++; $display("FAIL stall_addr got %h exp 8", bus.Address); end
    checks++;
    if (bus.InstrValid !== 1'b1 || bus.InstrOut !== 32'hD2800140 || bus.PCOut !== 64'h0) begin
      errors++;
      $display("FAIL stall_head got %b %h %h exp 1 D2800140 0", bus.InstrValid, bus.InstrOut, bus.PCOut);
    end
    bus.InstrReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.InstrValid !== 1'b1 || bus.InstrOut !== exp_words[i+1] || bus.PCOut !== ep[i]) begin
        errors++;
        $display("FAIL stall_drain%0d got %b %h %h exp 1 %h %h", i, bus.InstrValid,
                 bus.InstrOut, bus.PCOut, exp_words[i+1], ep[i]);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    for (int k = 1; k <= 6; k++) tick();
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 64'h13;
    bus.InstrReady = 1'b1;
    tick();
    bus.Redirect = 1'b0;
    checks++;
    if (bus.InstrValid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b exp 0", bus.InstrValid); end
    checks++;
    if (bus.Address !== 64'h10) begin errors++; $display("FAIL redir_addr got %h exp 10", bus.Address); end
    tick();
    checks++;
    if (bus.InstrValid !== 1'b0) begin errors++; $display("FAIL redir_wait got %b exp 0", bus.InstrValid); end
    tick();
    checks++;
    if (bus.InstrValid !== 1'b1 || bus.InstrOut !== 32'h0B010004 || bus.PCOut !== 64'h10) begin
      errors++;
      $display("FAIL redir_first got %b %h %h exp 1 0B010004 10", bus.InstrValid, bus.InstrOut, bus.PCOut);
    end
  endtask

  task automatic test_halt();
    do_reset(1'b0);
    for (int k = 1; k <= 4; k++) tick();
    bus.FetchEnable = 1'b0;
    bus.InstrReady  = 1'b1;
    tick();
    checks++;
    if (bus.Address !== 64'h8 || bus.InstrValid !== 1'b1 || bus.PCOut !== 64'h4) begin
      errors++;
      $display("FAIL halt_drain got %h %b %h exp 8 1 4", bus.Address, bus.InstrValid, bus.PCOut);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (bus.Address !== 64'h8 || bus.InstrValid !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold%0d got %h %b exp 8 0", k, bus.Address, bus.InstrValid);
      end
    end
    bus.FetchEnable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (bus.Address !== 64'h8 || bus.InstrValid !== 1'b0) begin
        errors++;
        $display("FAIL halt_rewait%0d got %h %b exp 8 0", k, bus.Address, bus.InstrValid);
      end
    end
    tick();
    checks++;
    if (bus.InstrValid !== 1'b1 || bus.InstrOut !== 32'hD28001E2 || bus.PCOut !== 64'h8
        || bus.Address !== 64'hC) begin
      errors++;
      $display("FAIL halt_resume got %b %h %h %h exp 1 D28001E2 8 C", bus.InstrValid,
               bus.InstrOut, bus.PCOut, bus.Address);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    bus.Redirect = 1'b0;
    checks++;
    if (bus.Address !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_target got %h exp FFFFFFFFFFFFFFFC", bus.Address);
    end
    tick();
    tick();
    checks++;
    if (bus.Address !== 64'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", bus.Address); end
    checks++;
    if (bus.InstrValid !== 1'b1 || bus.PCOut !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_head got %b %h exp 1 FFFFFFFFFFFFFFFC", bus.InstrValid, bus.PCOut);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    for (int k = 1; k <= 6; k++) tick();
    #3;
    Reset = 1'b1;
    #1;
    checks++;
    if (bus.InstrValid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", bus.InstrValid); end
    checks++;
    if (bus.InstrOut !== 32'h0) begin errors++; $display("FAIL arst_instr got %h exp 0", bus.InstrOut); end
    checks++;
    if (bus.PCOut !== 64'h0) begin errors++; $display("FAIL arst_pcout got %h exp 0", bus.PCOut); end
    checks++;
    if (bus.Address !== 64'h0) begin errors++; $display("FAIL arst_addr got %h exp 0", bus.Address); end
    bus.InstrReady = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    check_stream("arst");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
